// File: rtl/dmem_arbiter_if.sv
// Purpose: requester and data-memory bundle shared by dmem_arbiter and its environment.
// Latency: none; wires only.
// Backpressure: requesters hold req and their fields until the matching gnt strobe.
interface dmem_arbiter_if;
  // requester side, two ports packed side by side
  logic [1:0]  req;
  logic [1:0]  wr;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  mask;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        err;
  logic [31:0] rdata;
  logic        busy;
  // data memory side
  logic        mem_ce;
  logic        mem_we;
  logic        mem_memRr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wtData;
  logic [3:0]  mem_w_mask;
  logic [3:0]  mem_r_mask;
  logic [31:0] mem_rdData;

  // arbiter view
  modport slave (
    input  req, wr, addr, wdata, mask, mem_rdData,
    output gnt, done, err, rdata, busy,
    output mem_ce, mem_we, mem_memRr, mem_addr, mem_wtData, mem_w_mask, mem_r_mask
  );

  // requester plus memory-model view
  modport master (
    output req, wr, addr, wdata, mask, mem_rdData,
    input  gnt, done, err, rdata, busy,
    input  mem_ce, mem_we, mem_memRr, mem_addr, mem_wtData, mem_w_mask, mem_r_mask
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: two-port data-memory arbiter (CPU port 0 priority, debug port 1 anti-starvation).
// Latency: read done at accept+3, sub-word write at +2, full write and out-of-range at +1.
// Backpressure: only one operation in flight; gnt is given only in IDLE, requesters hold until gnt.
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_A      = 3'd1,
    RD_B      = 3'd2,
    RD_RET    = 3'd3,
    WR_PRE    = 3'd4,
    WR_COMMIT = 3'd5
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state;
  logic        lat_port;
  logic [3:0]  lat_mask;
  logic [3:0]  starve_cnt;

  // registered outputs
  logic [1:0]  done_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        busy_q;
  logic        mem_ce_q;
  logic        mem_we_q;
  logic        mem_rr_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdat_q;
  logic [3:0]  mem_wm_q;
  logic [3:0]  mem_rm_q;

  // arbitration results
  logic        starved;
  logic        pick1;
  logic        accept;
  logic [1:0]  gnt;
  logic        sel_wr;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_mask;
  logic [1:0]  port_oh;

  // Pick a port in IDLE and mux its request fields for latching
  always_comb begin
    starved   = (starve_cnt >= STARVE_LIM);
    pick1     = bus.req[1] && (!bus.req[0] || starved);
    accept    = (state == IDLE) && (|bus.req);
    gnt       = 2'b00;
    if (accept) begin
      gnt = pick1 ? 2'b10 : 2'b01;
    end
    sel_wr    = pick1 ? bus.wr[1]          : bus.wr[0];
    sel_addr  = pick1 ? bus.addr[63:32]    : bus.addr[31:0];
    sel_wdata = pick1 ? bus.wdata[63:32]   : bus.wdata[31:0];
    sel_mask  = pick1 ? bus.mask[7:4]      : bus.mask[3:0];
    port_oh   = lat_port ? 2'b10 : 2'b01;
  end

  // Operation FSM; every output except gnt is a register so reset clears it at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_port   <= 1'b0;
      lat_mask   <= 4'd0;
      starve_cnt <= 4'd0;
      done_q     <= 2'b00;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
      busy_q     <= 1'b0;
      mem_ce_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_rr_q   <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_wdat_q <= 32'd0;
      mem_wm_q   <= 4'd0;
      mem_rm_q   <= 4'd0;
    end else begin
      done_q <= 2'b00;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          // Count only port-0 wins that made a waiting port 1 lose
          if (!bus.req[1] || pick1) begin
            starve_cnt <= 4'd0;
          end else if (accept && starve_cnt != 4'd15) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
          if (accept) begin
            lat_port   <= pick1;
            lat_mask   <= sel_mask;
            mem_addr_q <= sel_addr;
            mem_wdat_q <= sel_wdata;
            busy_q     <= 1'b1;
            if (|sel_addr[31:10]) begin
              // Out of range: report through RD_RET without touching memory
              state  <= RD_RET;
              done_q <= gnt;
              err_q  <= 1'b1;
            end else if (!sel_wr) begin
              state    <= RD_A;
              mem_ce_q <= 1'b1;
            end else if (sel_mask == 4'b0001 || sel_mask == 4'b0011) begin
              // Sub-word writes get a preparation cycle so the memory can merge
              state    <= WR_PRE;
              mem_ce_q <= 1'b1;
            end else begin
              state    <= WR_COMMIT;
              mem_ce_q <= 1'b1;
              mem_we_q <= 1'b1;
              mem_wm_q <= 4'b1111;
              done_q   <= gnt;
            end
          end
        end
        RD_A: begin
          state    <= RD_B;
          mem_rr_q <= 1'b1;
          mem_rm_q <= lat_mask;
        end
        RD_B: begin
          state    <= RD_RET;
          mem_ce_q <= 1'b0;
          mem_rr_q <= 1'b0;
          mem_rm_q <= 4'd0;
          done_q   <= port_oh;
          rdata_q  <= bus.mem_rdData;
        end
        RD_RET: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        WR_PRE: begin
          state    <= WR_COMMIT;
          mem_we_q <= 1'b1;
          mem_wm_q <= lat_mask;
          done_q   <= port_oh;
        end
        WR_COMMIT: begin
          state    <= IDLE;
          busy_q   <= 1'b0;
          mem_ce_q <= 1'b0;
          mem_we_q <= 1'b0;
          mem_wm_q <= 4'd0;
        end
        default: begin
          state    <= IDLE;
          busy_q   <= 1'b0;
          mem_ce_q <= 1'b0;
          mem_we_q <= 1'b0;
          mem_rr_q <= 1'b0;
          mem_wm_q <= 4'd0;
          mem_rm_q <= 4'd0;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.rdata      = rdata_q;
  assign bus.busy       = busy_q;
  assign bus.mem_ce     = mem_ce_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_memRr  = mem_rr_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wtData = mem_wdat_q;
  assign bus.mem_w_mask = mem_wm_q;
  assign bus.mem_r_mask = mem_rm_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: directed bench for dmem_arbiter with a small byte-merging memory model.
// Latency: checks each cycle offset after accept against hand-computed values.
// Backpressure: requests are held until gnt, then dropped.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   ce_cnt;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: synchronous read, byte-masked write
  logic [31:0] mem [0:1023];
  logic [31:0] rd_q;
  assign bus.mem_rdData = rd_q;

  always @(posedge clk) begin
    if (bus.mem_ce) begin
      ce_cnt = ce_cnt + 1;
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_w_mask[b]) mem[bus.mem_addr[9:0]][8*b +: 8] = bus.mem_wtData[8*b +: 8];
        end
      end else begin
        rd_q <= mem[bus.mem_addr[9:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req   = 2'b00;
    bus.wr    = 2'b00;
    bus.addr  = 64'd0;
    bus.wdata = 64'd0;
    bus.mask  = 8'd0;
  endtask

  int          got;
  logic [1:0]  order [0:9];
  logic [1:0]  exp_order [0:9];
  int          ce_before;

  initial begin
    tests  = 0;
    fails  = 0;
    ce_cnt = 0;
    rd_q   = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[16] = 32'hDEADBEEF;
    mem[32] = 32'h11223344;
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    idle_inputs();
    rst = 1'b1;

    // reset state
    cyc(); cyc();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_mem_ce", bus.mem_ce, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_rdata", bus.rdata, 0);
    rst = 1'b0;

    // read port 0, addr 0x10
    cyc();
    bus.req = 2'b01; bus.wr = 2'b00; bus.addr[31:0] = 32'h10; bus.mask[3:0] = 4'hF;
    #1;
    chk("rd_gnt_T", bus.gnt, 2'b01);
    cyc(); idle_inputs(); #1;
    chk("rd_ce_T1", bus.mem_ce, 1);
    chk("rd_rr_T1", bus.mem_memRr, 0);
    chk("rd_addr_T1", bus.mem_addr, 32'h10);
    chk("rd_busy_T1", bus.busy, 1);
    cyc();
    chk("rd_rr_T2", bus.mem_memRr, 1);
    chk("rd_ce_T2", bus.mem_ce, 1);
    chk("rd_addr_T2", bus.mem_addr, 32'h10);
    chk("rd_rmask_T2", bus.mem_r_mask, 4'hF);
    chk("rd_done_T2", bus.done, 0);
    cyc();
    chk("rd_done_T3", bus.done, 2'b01);
    chk("rd_rdata_T3", bus.rdata, 32'hDEADBEEF);
    chk("rd_err_T3", bus.err, 0);
    chk("rd_ce_T3", bus.mem_ce, 0);
    cyc();
    chk("rd_done_T4", bus.done, 0);
    chk("rd_busy_T4", bus.busy, 0);

    // byte write on port 1: addr 0x20, wdata 0xAA, mask 0001
    bus.req = 2'b10; bus.wr = 2'b10; bus.addr[63:32] = 32'h20;
    bus.wdata[63:32] = 32'hAA; bus.mask[7:4] = 4'b0001;
    #1;
    chk("bw_gnt_T", bus.gnt, 2'b10);
    cyc(); idle_inputs(); #1;
    chk("bw_pre_ce", bus.mem_ce, 1);
    chk("bw_pre_we", bus.mem_we, 0);
    chk("bw_pre_done", bus.done, 0);
    chk("bw_wdata", bus.mem_wtData, 32'hAA);
    cyc();
    chk("bw_commit_we", bus.mem_we, 1);
    chk("bw_commit_wmask", bus.mem_w_mask, 4'b0001);
    chk("bw_commit_done", bus.done, 2'b10);
    chk("bw_commit_addr", bus.mem_addr, 32'h20);
    cyc();
    chk("bw_after_we", bus.mem_we, 0);
    chk("bw_after_busy", bus.busy, 0);
    // read back 0x20 on port 0
    bus.req = 2'b01; bus.addr[31:0] = 32'h20; bus.mask[3:0] = 4'hF;
    #1;
    chk("bw_rb_gnt", bus.gnt, 2'b01);
    cyc(); idle_inputs();
    cyc(); cyc();
    chk("bw_rb_done", bus.done, 2'b01);
    chk("bw_rb_rdata", bus.rdata, 32'h112233AA);
    cyc();

    // full write port 0 with mask 0110 -> single commit, forced full mask
    bus.req = 2'b01; bus.wr = 2'b01; bus.addr[31:0] = 32'h30;
    bus.wdata[31:0] = 32'hCAFEF00D; bus.mask[3:0] = 4'b0110;
    #1;
    chk("fw_gnt_T", bus.gnt, 2'b01);
    cyc(); idle_inputs(); #1;
    chk("fw_done_T1", bus.done, 2'b01);
    chk("fw_we_T1", bus.mem_we, 1);
    chk("fw_ce_T1", bus.mem_ce, 1);
    chk("fw_wmask_T1", bus.mem_w_mask, 4'b1111);
    chk("fw_wdata_T1", bus.mem_wtData, 32'hCAFEF00D);
    cyc();
    chk("fw_done_T2", bus.done, 0);
    chk("fw_we_T2", bus.mem_we, 0);
    chk("fw_busy_T2", bus.busy, 0);
    chk("fw_mem", mem[48], 32'hCAFEF00D);

    // out-of-range read to 0x400
    ce_before = ce_cnt;
    bus.req = 2'b01; bus.wr = 2'b00; bus.addr[31:0] = 32'h400; bus.mask[3:0] = 4'hF;
    #1;
    chk("oor_gnt_T", bus.gnt, 2'b01);
    cyc(); idle_inputs(); #1;
    chk("oor_done_T1", bus.done, 2'b01);
    chk("oor_err_T1", bus.err, 1);
    chk("oor_ce_T1", bus.mem_ce, 0);
    cyc();
    chk("oor_done_T2", bus.done, 0);
    chk("oor_err_T2", bus.err, 0);
    chk("oor_busy_T2", bus.busy, 0);
    chk("oor_no_ce", ce_cnt - ce_before, 0);

    // starvation: both ports read 0x10 continuously
    bus.req = 2'b11; bus.wr = 2'b00;
    bus.addr = {32'h10, 32'h10}; bus.mask = 8'hFF;
    got = 0;
    #1;
    for (int c = 0; c < 80 && got < 10; c++) begin
      if (bus.gnt != 2'b00) begin
        order[got] = bus.gnt;
        got++;
      end
      if (got < 10) cyc();
    end
    cyc(); idle_inputs();
    chk("starve_count", got, 10);
    for (int i = 0; i < got; i++) begin
      chk($sformatf("starve_gnt_%0d", i), order[i], exp_order[i]);
    end
    for (int c = 0; c < 20 && bus.busy; c++) cyc();
    chk("starve_drain_busy", bus.busy, 0);

    // reset during RD_B aborts the read without a clock edge
    cyc();
    bus.req = 2'b01; bus.wr = 2'b00; bus.addr[31:0] = 32'h10; bus.mask[3:0] = 4'hF;
    #1;
    chk("ra_gnt", bus.gnt, 2'b01);
    cyc(); idle_inputs();
    cyc();
    chk("ra_rr_before", bus.mem_memRr, 1);
    rst = 1'b1;
    #1;
    chk("ra_ce_async", bus.mem_ce, 0);
    chk("ra_rr_async", bus.mem_memRr, 0);
    chk("ra_busy_async", bus.busy, 0);
    chk("ra_done_async", bus.done, 0);
    cyc();
    chk("ra_done_next", bus.done, 0);
    rst = 1'b0;
    cyc();
    chk("ra_done_after", bus.done, 0);
    chk("ra_busy_after", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
